// File: rtl/datapath_section3_ctrl_pkg.sv
// Shared types for the datapath_section3 search-loop controller.
// Holds the state enum, mux select names and the control-word decoder.
package ds3_pkg;

  localparam int unsigned WIDTH_DEF    = 16;
  localparam int unsigned MAX_ITER_DEF = 1024;

  localparam logic SEL_TWO  = 1'b1;
  localparam logic SEL_HOLD = 1'b0;
  localparam logic SEL_SUB  = 1'b0;
  localparam logic SEL_B    = 1'b1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    INIT = 3'd1,
    EVAL = 3'd2,
    INCR = 3'd3,
    STEP = 3'd4,
    SAVE = 3'd5,
    DONE = 3'd6
  } state_t;

  typedef struct packed {
    logic ctrl3;
    logic ctrl4;
    logic ctrl5;
    logic ctrl8;
    logic ctrl9;
  } ctrl_t;

  // Datapath control word for a state; first picks two vs hold_m when saving.
  function automatic ctrl_t decode_ctrl(input state_t s, input logic first);
    ctrl_t c;
    c = '0;
    case (s)
      INIT: begin
        c.ctrl3 = SEL_TWO;
        c.ctrl9 = 1'b1;
        c.ctrl4 = SEL_SUB;
        c.ctrl8 = 1'b1;
      end
      INCR: c.ctrl5 = 1'b1;
      STEP: begin
        c.ctrl3 = SEL_HOLD;
        c.ctrl9 = 1'b1;
      end
      SAVE: begin
        c.ctrl3 = first ? SEL_TWO : SEL_HOLD;
        c.ctrl4 = SEL_B;
        c.ctrl8 = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/datapath_section3_ctrl_if.sv
// Controller-side bus: run request, evaluator handshake and datapath controls.
interface datapath_section3_ctrl_if #(
  parameter int unsigned WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] limit;
  logic [WIDTH-1:0] mout;
  logic             eval_valid;
  logic             eval_hit;
  logic             CTRL3;
  logic             CTRL4;
  logic             CTRL5;
  logic             CTRL8;
  logic             CTRL9;
  logic             busy;
  logic             done;
  logic             found;
  logic             timeout;

  modport master (
    output start, limit, mout, eval_valid, eval_hit,
    input  CTRL3, CTRL4, CTRL5, CTRL8, CTRL9, busy, done, found, timeout
  );

  modport slave (
    input  start, limit, mout, eval_valid, eval_hit,
    output CTRL3, CTRL4, CTRL5, CTRL8, CTRL9, busy, done, found, timeout
  );
endinterface

// File: rtl/datapath_section3_ctrl.sv
// Moore FSM stepping datapath_section3's m register until hit, limit or iteration cap.
// All outputs are registered from the next-state decode, so they track the state register.
module datapath_section3_ctrl
  import ds3_pkg::*;
#(
  parameter int unsigned WIDTH    = WIDTH_DEF,
  parameter int unsigned MAX_ITER = MAX_ITER_DEF
) (
  input logic                     CLK,
  input logic                     RST_N,
  datapath_section3_ctrl_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(MAX_ITER + 1);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] iter_cnt;
  logic [CNT_W-1:0] iter_next;
  logic             first;
  logic             first_next;
  logic             found_next;
  logic             timeout_next;
  ctrl_t            ctrl_next;
  logic [WIDTH-1:0] m_val;
  logic [WIDTH-1:0] lim_val;

  assign m_val   = bus.mout;
  assign lim_val = bus.limit;

  // Next-state, flag and control-word decode.
  always_comb begin
    state_next   = state;
    iter_next    = iter_cnt;
    first_next   = first;
    found_next   = bus.found;
    timeout_next = bus.timeout;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_next   = INIT;
          found_next   = 1'b0;
          timeout_next = 1'b0;
          iter_next    = '0;
        end
      end
      INIT: begin
        first_next = 1'b1;
        state_next = EVAL;
      end
      EVAL: begin
        if (bus.eval_valid) begin
          iter_next = iter_cnt + CNT_W'(1);
          if (bus.eval_hit) begin
            state_next = SAVE;
          end else if (m_val >= lim_val) begin
            state_next = DONE;
          end else if (32'(iter_cnt) + 32'd1 == 32'(MAX_ITER)) begin
            state_next   = DONE;
            timeout_next = 1'b1;
          end else begin
            state_next = INCR;
          end
        end
      end
      INCR: state_next = STEP;
      STEP: begin
        first_next = 1'b0;
        state_next = EVAL;
      end
      SAVE: begin
        found_next = 1'b1;
        state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    ctrl_next = decode_ctrl(state_next, first_next);
  end

  // State, counter and registered outputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state       <= IDLE;
      iter_cnt    <= '0;
      first       <= 1'b0;
      bus.CTRL3   <= 1'b0;
      bus.CTRL4   <= 1'b0;
      bus.CTRL5   <= 1'b0;
      bus.CTRL8   <= 1'b0;
      bus.CTRL9   <= 1'b0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.found   <= 1'b0;
      bus.timeout <= 1'b0;
    end else begin
      state       <= state_next;
      iter_cnt    <= iter_next;
      first       <= first_next;
      bus.CTRL3   <= ctrl_next.ctrl3;
      bus.CTRL4   <= ctrl_next.ctrl4;
      bus.CTRL5   <= ctrl_next.ctrl5;
      bus.CTRL8   <= ctrl_next.ctrl8;
      bus.CTRL9   <= ctrl_next.ctrl9;
      bus.busy    <= (state_next != IDLE);
      bus.done    <= (state_next == DONE);
      bus.found   <= found_next;
      bus.timeout <= timeout_next;
    end
  end

endmodule
